mem_port_arbiter: RTL and testbench

Parametrised N-channel arbiter sharing one off-chip memory port among cache controllers, generalising the fixed two-way I/D-cache arbitration. It provides fixed-priority or round-robin selection, ownership held for a whole miss fill, and read-in-flight tracking so ownership never changes while read data is still returning. It sits between the cache FSMs' off-chip sides and the main-memory model.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one off-chip memory port among NUM_CH cache controllers. Ownership is
// held for a whole fill and is not handed over while reads are still returning.
module mem_port_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int RR_MODE = 0,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [NUM_CH-1:0]    ch_wr,
    input  logic [NUM_CH*AW-1:0] ch_addr,
    input  logic [NUM_CH*DW-1:0] ch_wdata,
    output logic [NUM_CH-1:0]    ch_gnt,
    output logic [NUM_CH-1:0]    ch_accept,
    output logic [DW-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]    ch_rvalid,
    output logic                 mem_en,
    output logic                 mem_wr,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_rvalid
);
    localparam int OW = $clog2(NUM_CH);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

    state_t              state_q, state_n;
    logic [NUM_CH-1:0]   gnt_q, gnt_n;
    logic [OW-1:0]       owner_q, owner_n;
    logic [OW-1:0]       last_q, last_n;
    logic [OW-1:0]       rd_owner_q, rd_owner_n;
    logic [CW-1:0]       out_cnt, cnt_nxt;
    logic                err_q;

    logic [OW-1:0]       win;
    logic                win_vld;
    logic                accept, acc_rd, rv_ok, take;
    int                  idx;

    // Round-robin scans upward from the slot after the previous owner.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (RR_MODE != 0) ? (int'(last_q) + 1 + k) % NUM_CH : k;
            if (!win_vld && ch_req[idx]) begin
                win_vld = 1'b1;
                win     = OW'(idx);
            end
        end
    end

    assign accept = gnt_q[owner_q] & ch_en[owner_q]
                  & (ch_wr[owner_q] | (out_cnt < CW'(MAX_OUT)));
    assign acc_rd = accept & ~ch_wr[owner_q];
    // A return with nothing outstanding is dropped rather than underflowing.
    assign rv_ok  = mem_rvalid & (out_cnt != '0);

    assign ch_gnt    = gnt_q;
    assign mem_en    = accept;
    assign mem_wr    = accept & ch_wr[owner_q];
    assign mem_addr  = gnt_q[owner_q] ? ch_addr[int'(owner_q)*AW +: AW]  : '0;
    assign mem_wdata = gnt_q[owner_q] ? ch_wdata[int'(owner_q)*DW +: DW] : '0;
    assign ch_rdata  = mem_rdata;

    always_comb begin
        ch_accept          = '0;
        ch_accept[owner_q] = accept;
        ch_rvalid             = '0;
        ch_rvalid[rd_owner_q] = rv_ok;
    end

    always_comb begin
        cnt_nxt = out_cnt;
        if (acc_rd && !rv_ok)      cnt_nxt = out_cnt + CW'(1);
        else if (!acc_rd && rv_ok) cnt_nxt = out_cnt - CW'(1);
    end

    // Handover only once the count settles at zero, so a final return landing
    // in the release cycle still hands over on that edge.
    always_comb begin
        state_n    = state_q;
        gnt_n      = gnt_q;
        owner_n    = owner_q;
        last_n     = last_q;
        rd_owner_n = rd_owner_q;
        take       = 1'b0;
        case (state_q)
            IDLE: take = 1'b1;
            OWN: begin
                if (!ch_req[owner_q]) begin
                    if (cnt_nxt == '0) begin
                        take = 1'b1;
                    end else begin
                        state_n = DRAIN;
                        gnt_n   = '0;
                    end
                end
            end
            DRAIN: if (cnt_nxt == '0) take = 1'b1;
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
        if (take) begin
            gnt_n = '0;
            if (win_vld) begin
                state_n    = OWN;
                gnt_n[win] = 1'b1;
                owner_n    = win;
                last_n     = win;
                rd_owner_n = win;
            end else begin
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            last_q     <= OW'(NUM_CH - 1);
            rd_owner_q <= '0;
            out_cnt    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            gnt_q      <= gnt_n;
            owner_q    <= owner_n;
            last_q     <= last_n;
            rd_owner_q <= rd_owner_n;
            out_cnt    <= cnt_nxt;
            if (mem_rvalid && out_cnt == '0) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 2-channel fixed-priority arbiter and a 4-channel round-robin one.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // 2-channel fixed-priority instance
    logic [1:0]  req = '0, en = '0, wr = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  gnt, acc, rvld;
    logic [15:0] rdata, m_addr, m_wdata, m_rdata = '0;
    logic        m_en, m_wr, m_rvalid = 1'b0;

    mem_port_arbiter #(.NUM_CH(2), .AW(16), .DW(16), .RR_MODE(0), .MAX_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(req), .ch_en(en), .ch_wr(wr),
        .ch_addr(addr), .ch_wdata(wdata), .ch_gnt(gnt), .ch_accept(acc),
        .ch_rdata(rdata), .ch_rvalid(rvld), .mem_en(m_en), .mem_wr(m_wr),
        .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_rdata(m_rdata), .mem_rvalid(m_rvalid));

    // 4-channel round-robin instance
    logic [3:0]  r_req = '0, r_en = '0, r_wr = '0;
    logic [63:0] r_addr = '0, r_wdata = '0;
    logic [3:0]  r_gnt, r_acc, r_rvld;
    logic [15:0] r_rdata, r_maddr, r_mwdata;
    logic        r_men, r_mwr;

    mem_port_arbiter #(.NUM_CH(4), .AW(16), .DW(16), .RR_MODE(1), .MAX_OUT(4)) dut_rr (
        .clk(clk), .rst_n(rst_n), .ch_req(r_req), .ch_en(r_en), .ch_wr(r_wr),
        .ch_addr(r_addr), .ch_wdata(r_wdata), .ch_gnt(r_gnt), .ch_accept(r_acc),
        .ch_rdata(r_rdata), .ch_rvalid(r_rvld), .mem_en(r_men), .mem_wr(r_mwr),
        .mem_addr(r_maddr), .mem_wdata(r_mwdata), .mem_rdata(16'h0), .mem_rvalid(1'b0));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt;
    logic exp_acc;

    initial begin
        // Reset state
        #7;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_mem_en", 32'(m_en), 0);
        chk("rst_cnt", 32'(dut.out_cnt), 0);
        chk("rst_err", 32'(dut.err_q), 0);
        chk("rst_last_rr", 32'(dut_rr.last_q), 3);
        rst_n = 1'b1;
        tick();
        chk("idle_gnt", 32'(gnt), 0);

        // Round-robin order 0,1,2,3,0: owner drops its request for one cycle
        r_req = 4'b1111;
        tick();
        chk("rr_g0", 32'(r_gnt), 'h1);
        r_req = 4'b1110; tick(); chk("rr_g1", 32'(r_gnt), 'h2);
        r_req = 4'b1101; tick(); chk("rr_g2", 32'(r_gnt), 'h4);
        r_req = 4'b1011; tick(); chk("rr_g3", 32'(r_gnt), 'h8);
        r_req = 4'b0111; tick(); chk("rr_g0b", 32'(r_gnt), 'h1);
        r_req = 4'b0000;

        // Fixed-priority collision: ch0 wins, 4 reads over 6 owned cycles
        req = 2'b11;
        tick();
        chk("fp_gnt0", 32'(gnt), 'h1);
        for (int i = 0; i < 4; i++) begin
            en = 2'b01; wr = 2'b00;
            addr = {16'h0555, 16'(16'h0100 + i)};
            #1;
            chk("fp_acc", 32'(acc), 'h1);
            chk("fp_addr", 32'(m_addr), 32'(16'h0100 + i));
            tick();
        end
        en = 2'b00;
        tick(); tick();
        chk("fp_cnt4", 32'(dut.out_cnt), 4);
        req = 2'b10;
        tick();
        chk("fp_drain_gnt", 32'(gnt), 0);
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1; m_rdata = 16'(16'hD000 + k);
            #1;
            chk("fp_rvalid", 32'(rvld), 'h1);
            chk("fp_rdata", 32'(rdata), 32'(16'hD000 + k));
            tick();
            chk("fp_handover", 32'(gnt), (k < 3) ? 0 : 'h2);
        end
        m_rvalid = 1'b0;

        // Write-through from ch1; ch0's out-of-band enable is ignored
        en = 2'b11; wr = 2'b10;
        addr = {16'h00A4, 16'h0555}; wdata = {16'hBEEF, 16'h1234};
        #1;
        chk("wt_acc", 32'(acc), 'h2);
        chk("wt_en", 32'(m_en), 1);
        chk("wt_wr", 32'(m_wr), 1);
        chk("wt_addr", 32'(m_addr), 'h00A4);
        chk("wt_data", 32'(m_wdata), 'hBEEF);
        tick();
        chk("wt_cnt", 32'(dut.out_cnt), 0);

        // Outstanding limit: read every cycle, returns begin 6 cycles after the first issue
        en = 2'b10; wr = 2'b00;
        exp_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            m_rvalid = (t >= 6);
            exp_acc = (exp_cnt < 4);
            #1;
            chk("lim_acc", 32'(acc), exp_acc ? 'h2 : 0);
            tick();
            exp_cnt = exp_cnt + (exp_acc ? 1 : 0) - ((t >= 6 && exp_cnt > 0) ? 1 : 0);
            chk("lim_cnt", 32'(dut.out_cnt), 32'(exp_cnt));
        end
        en = 2'b00; m_rvalid = 1'b1;
        tick();
        chk("sim_pre", 32'(dut.out_cnt), 2);
        en = 2'b10;
        tick();
        chk("sim_cnt", 32'(dut.out_cnt), 2);
        en = 2'b00;
        tick(); tick();
        chk("drain_cnt", 32'(dut.out_cnt), 0);
        chk("err_before", 32'(dut.err_q), 0);
        tick();
        chk("spur_err", 32'(dut.err_q), 1);
        chk("spur_cnt", 32'(dut.out_cnt), 0);
        m_rvalid = 1'b0;

        // Asynchronous reset mid-fill
        en = 2'b10;
        tick();
        chk("pre_rst_cnt", 32'(dut.out_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_men", 32'(m_en), 0);
        chk("arst_acc", 32'(acc), 0);
        chk("arst_addr", 32'(m_addr), 0);
        chk("arst_cnt", 32'(dut.out_cnt), 0);
        chk("arst_err", 32'(dut.err_q), 0);
        en = 2'b00; req = 2'b01;
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_gnt", 32'(gnt), 'h1);
        m_rvalid = 1'b1;
        #1;
        chk("late_rvld", 32'(rvld), 0);
        tick();
        chk("late_err", 32'(dut.err_q), 1);
        m_rvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
